// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request/response bundle between the two requesters and dmem_arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic              req0_lock;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic              req1_lock;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;

    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata
    );

    modport master (
        output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter/sequencer for a single-port data memory with locked sequences
// Define DMEM_ARB_RR_EN for round-robin conflict resolution; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              resetn,
    dmem_arbiter_if.slave     bus,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              lock_timeout
);
    typedef enum logic [1:0] {
        OPEN = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] IDLE_LAST = 8'(LOCK_MAX - 1);

    state_t            state, state_nxt;
    logic [7:0]        idle_cnt, idle_nxt;
    logic              rdy0, rdy1, pick1;
    logic              acc0, acc1, acc;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              s1_v, s1_tag, s2_v, s2_tag;
    logic              rsp0_v, rsp1_v;
    logic [DATA_W-1:0] hold0, hold1;

`ifdef DMEM_ARB_RR_EN
    logic              rr_ptr;
`endif

    always_comb begin
        rdy0  = 1'b0;
        rdy1  = 1'b0;
        pick1 = 1'b0;
        case (state)
            OWN0: rdy0 = bus.req0_valid;
            OWN1: rdy1 = bus.req1_valid;
            default: begin
`ifdef DMEM_ARB_RR_EN
                pick1 = bus.req1_valid && (!bus.req0_valid || rr_ptr);
`else
                pick1 = bus.req1_valid && !bus.req0_valid;
`endif
                rdy0  = bus.req0_valid && !pick1;
                rdy1  = pick1;
            end
        endcase
        if (!resetn) begin
            rdy0 = 1'b0;
            rdy1 = 1'b0;
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign acc0      = bus.req0_valid && rdy0;
    assign acc1      = bus.req1_valid && rdy1;
    assign acc       = acc0 || acc1;
    assign acc_we    = acc1 ? bus.req1_we    : bus.req0_we;
    assign acc_addr  = acc1 ? bus.req1_addr  : bus.req0_addr;
    assign acc_wdata = acc1 ? bus.req1_wdata : bus.req0_wdata;

    // In OWNx with no accepted beat the owner must be idle, so that cycle counts toward release.
    always_comb begin
        state_nxt    = state;
        idle_nxt     = idle_cnt;
        lock_timeout = 1'b0;
        if (acc0) begin
            state_nxt = bus.req0_lock ? OWN0 : OPEN;
            idle_nxt  = '0;
        end else if (acc1) begin
            state_nxt = bus.req1_lock ? OWN1 : OPEN;
            idle_nxt  = '0;
        end else if (state != OPEN) begin
            if (idle_cnt == IDLE_LAST) begin
                state_nxt    = OPEN;
                idle_nxt     = '0;
                lock_timeout = 1'b1;
            end else begin
                idle_nxt = idle_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= OPEN;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_nxt;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= 1'b0;
        end else if (acc) begin
            rr_ptr <= !acc1;
        end
    end
`endif

    // Read tags ride two stages so they line up with mem_rd from the registered memory.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
            s1_v     <= 1'b0;
            s1_tag   <= 1'b0;
            s2_v     <= 1'b0;
            s2_tag   <= 1'b0;
            hold0    <= '0;
            hold1    <= '0;
        end else begin
            mem_we <= acc && acc_we;
            if (acc) begin
                mem_addr <= acc_addr;
                mem_wd   <= acc_wdata;
            end
            s1_v   <= acc && !acc_we;
            s1_tag <= acc1;
            s2_v   <= s1_v;
            s2_tag <= s1_tag;
            if (rsp0_v) hold0 <= mem_rd;
            if (rsp1_v) hold1 <= mem_rd;
        end
    end

    assign rsp0_v         = s2_v && !s2_tag;
    assign rsp1_v         = s2_v && s2_tag;
    assign bus.rsp0_valid = rsp0_v;
    assign bus.rsp1_valid = rsp1_v;
    assign bus.rsp0_rdata = rsp0_v ? mem_rd : hold0;
    assign bus.rsp1_rdata = rsp1_v ? mem_rd : hold1;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
    localparam int ADDR_W   = 9;
    localparam int DATA_W   = 32;
    localparam int LOCK_MAX = 16;

    typedef struct packed {
        logic        v;
        logic        we;
        logic        lock;
        logic [8:0]  addr;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } rd_t;

    localparam beat_t IDLE = '0;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_init;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        lock_timeout;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd),
        .lock_timeout (lock_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    logic [31:0] mem [0:511];
    always_ff @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wd;
        end
        mem_rd <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the memory, how long the owner has idled, who was served last,
    // plus a shadow of memory contents and the reads still owed to each port.
    int          owner;
    int          idle;
    int          last_srv;
    int          cyc = 0;
    logic        exp_we;
    logic [8:0]  exp_addr;
    logic [31:0] exp_wd;
    logic [31:0] hold [2];
    logic [31:0] ref_mem [512];
    rd_t         pend [$];

    task automatic model_reset();
        owner    = -1;
        idle     = 0;
        last_srv = 1;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_wd   = '0;
        hold[0]  = '0;
        hold[1]  = '0;
        pend.delete();
    endtask

    function automatic beat_t mk(input logic v, input logic we, input logic lk,
                                 input logic [8:0] a, input logic [31:0] d);
        beat_t b;
        b.v = v; b.we = we; b.lock = lk; b.addr = a; b.data = d;
        return b;
    endfunction

    function automatic beat_t rnd_beat(input int pct);
        beat_t b;
        b.v    = ($urandom_range(0, 99) < 32'(pct));
        b.we   = 1'($urandom_range(0, 1));
        b.lock = ($urandom_range(0, 3) == 0);
        b.addr = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 7));
        b.data = $urandom();
        return b;
    endfunction

    task automatic cycle(input logic rn, input beat_t b0, input beat_t b1);
        logic        er0, er1, eto, owner_v;
        logic [1:0]  erv;
        logic [31:0] erd [2];
        beat_t       bg;
        int          g;
        rd_t         r;
        @(negedge clk);
        resetn         = rn;
        bus.req0_valid = b0.v;  bus.req0_we = b0.we;  bus.req0_lock = b0.lock;
        bus.req0_addr  = b0.addr; bus.req0_wdata = b0.data;
        bus.req1_valid = b1.v;  bus.req1_we = b1.we;  bus.req1_lock = b1.lock;
        bus.req1_addr  = b1.addr; bus.req1_wdata = b1.data;
        #1;
        if (!rn) model_reset();
        er0 = 1'b0;
        er1 = 1'b0;
        if (rn) begin
            if (owner == 0) er0 = b0.v;
            else if (owner == 1) er1 = b1.v;
            else if (b0.v && b1.v) begin
`ifdef DMEM_ARB_RR_EN
                if (last_srv == 0) er1 = 1'b1; else er0 = 1'b1;
`else
                er0 = 1'b1;
`endif
            end else begin
                er0 = b0.v;
                er1 = b1.v;
            end
        end
        owner_v = (owner == 0) ? b0.v : b1.v;
        eto     = rn && (owner >= 0) && !owner_v && (idle + 1 == LOCK_MAX);
        erv     = 2'b00;
        erd[0]  = hold[0];
        erd[1]  = hold[1];
        if (pend.size() > 0 && pend[0].due == cyc) begin
            erv[pend[0].port] = 1'b1;
            erd[pend[0].port] = pend[0].data;
        end

        check("req0_ready",   32'(bus.req0_ready), 32'(er0));
        check("req1_ready",   32'(bus.req1_ready), 32'(er1));
        check("lock_timeout", 32'(lock_timeout),   32'(eto));
        check("rsp0_valid",   32'(bus.rsp0_valid), 32'(erv[0]));
        check("rsp1_valid",   32'(bus.rsp1_valid), 32'(erv[1]));
        check("rsp0_rdata",   bus.rsp0_rdata,      erd[0]);
        check("rsp1_rdata",   bus.rsp1_rdata,      erd[1]);
        check("mem_we",       32'(mem_we),         32'(exp_we));
        check("mem_addr",     32'(mem_addr),       32'(exp_addr));
        check("mem_wd",       mem_wd,              exp_wd);

        if (rn) begin
            if (erv != 2'b00) begin
                hold[pend[0].port] = pend[0].data;
                pend.delete(0);
            end
            if (er0 || er1) begin
                g        = er1 ? 1 : 0;
                bg       = er1 ? b1 : b0;
                exp_we   = bg.we;
                exp_addr = bg.addr;
                exp_wd   = bg.data;
                if (bg.we) begin
                    ref_mem[bg.addr] = bg.data;
                end else begin
                    r.port = g;
                    r.data = ref_mem[bg.addr];
                    r.due  = cyc + 2;
                    pend.push_back(r);
                end
                last_srv = g;
                owner    = bg.lock ? g : -1;
                idle     = 0;
            end else begin
                exp_we = 1'b0;
                if (owner >= 0) begin
                    idle++;
                    if (idle == LOCK_MAX) begin
                        owner = -1;
                        idle  = 0;
                    end
                end
            end
        end
        cyc++;
    endtask

    initial begin
        int pct;
        resetn   = 1'b0;
        mem_init = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_lock = 1'b0;
        bus.req0_addr  = '0;   bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_lock = 1'b0;
        bus.req1_addr  = '0;   bus.req1_wdata = '0;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
        model_reset();
        @(posedge clk);
        #1 mem_init = 1'b0;

        // Reset holds everything quiet even with requests pending.
        cycle(1'b0, mk(1'b1, 1'b0, 1'b0, 9'd3, 32'd0), mk(1'b1, 1'b1, 1'b0, 9'd4, 32'd7));
        cycle(1'b0, IDLE, IDLE);

        // Single read of a freshly written word.
        cycle(1'b1, mk(1'b1, 1'b1, 1'b0, 9'd5, 32'hDEAD_BEEF), IDLE);
        cycle(1'b1, mk(1'b1, 1'b0, 1'b0, 9'd5, 32'd0), IDLE);
        cycle(1'b1, IDLE, IDLE);
        cycle(1'b1, IDLE, IDLE);
        check("single_rd_v",    32'(bus.rsp0_valid), 32'd1);
        check("single_rd_data", bus.rsp0_rdata,      32'hDEAD_BEEF);
        check("single_rd_p1",   32'(bus.rsp1_valid), 32'd0);

        // Write then read at the top address.
        cycle(1'b1, IDLE, mk(1'b1, 1'b1, 1'b0, 9'd511, 32'h1234_5678));
        cycle(1'b1, IDLE, mk(1'b1, 1'b0, 1'b0, 9'd511, 32'd0));
        cycle(1'b1, IDLE, IDLE);
        cycle(1'b1, IDLE, IDLE);
        check("raw_511_v",    32'(bus.rsp1_valid), 32'd1);
        check("raw_511_data", bus.rsp1_rdata,      32'h1234_5678);

        // Both ports read every cycle.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, mk(1'b1, 1'b0, 1'b0, 9'(16 + i), 32'd0), mk(1'b1, 1'b0, 1'b0, 9'(32 + i), 32'd0));
`ifdef DMEM_ARB_RR_EN
            check("conflict_r0", 32'(bus.req0_ready), 32'(i % 2 == 0));
            check("conflict_r1", 32'(bus.req1_ready), 32'(i % 2 == 1));
`else
            check("conflict_r0", 32'(bus.req0_ready), 32'd1);
            check("conflict_r1", 32'(bus.req1_ready), 32'd0);
`endif
        end
        cycle(1'b1, IDLE, IDLE);
        cycle(1'b1, IDLE, IDLE);

        // Port 1 locked sequence with port 0 waiting.
        cycle(1'b1, IDLE, mk(1'b1, 1'b1, 1'b1, 9'd60, 32'hA0A0_0001));
        cycle(1'b1, mk(1'b1, 1'b0, 1'b0, 9'd60, 32'd0), mk(1'b1, 1'b1, 1'b1, 9'd61, 32'hA0A0_0002));
        check("lock_blk_a", 32'(bus.req0_ready), 32'd0);
        cycle(1'b1, mk(1'b1, 1'b0, 1'b0, 9'd60, 32'd0), mk(1'b1, 1'b0, 1'b0, 9'd61, 32'd0));
        check("lock_blk_b", 32'(bus.req0_ready), 32'd0);
        cycle(1'b1, mk(1'b1, 1'b0, 1'b0, 9'd60, 32'd0), IDLE);
        check("lock_release", 32'(bus.req0_ready), 32'd1);

        // Port 0 locks then goes quiet until the idle timeout frees the memory.
        cycle(1'b1, mk(1'b1, 1'b0, 1'b1, 9'd40, 32'd0), IDLE);
        for (int i = 0; i < LOCK_MAX; i++) begin
            cycle(1'b1, IDLE, mk(1'b1, 1'b0, 1'b0, 9'd41, 32'd0));
            check("to_r1_blocked", 32'(bus.req1_ready), 32'd0);
            check("to_pulse",      32'(lock_timeout),   32'(i == LOCK_MAX - 1));
        end
        cycle(1'b1, IDLE, mk(1'b1, 1'b0, 1'b0, 9'd41, 32'd0));
        check("to_r1_grant", 32'(bus.req1_ready), 32'd1);

        // Reset right after a read is accepted drops its response.
        cycle(1'b1, mk(1'b1, 1'b0, 1'b0, 9'd5, 32'd0), IDLE);
        cycle(1'b0, IDLE, IDLE);
        cycle(1'b1, IDLE, IDLE);
        check("rst_drop_rsp0", 32'(bus.rsp0_valid), 32'd0);
        check("rst_drop_rsp1", 32'(bus.rsp1_valid), 32'd0);
        cycle(1'b1, IDLE, IDLE);

        // Random traffic in busy and sparse stretches; sparse stretches exercise lock timeouts.
        for (int seg = 0; seg < 14; seg++) begin
            pct = ($urandom_range(0, 2) == 0) ? 8 : 75;
            for (int i = 0; i < 40; i++) cycle(1'b1, rnd_beat(pct), rnd_beat(pct));
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, IDLE, IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
